// File: rtl/sram_magic_monitor.sv
// sram_magic_monitor: passive snooper on one SRAM bus. It tracks writes to a
// small set of magic word addresses. For each address it keeps a byte-merged
// shadow word, emits one event per committed write, and latches sticky
// pass/fail/halt/timeout status for end-of-test detection.
module sram_magic_monitor #(
  parameter int                         ADDR_W         = 20,
  parameter int                         DATA_W         = 32,
  parameter int                         N_CHAN         = 2,
  // channel 0 = 20'h40000 (halt), channel 1 = 20'hC0000 (result)
  parameter logic [N_CHAN*ADDR_W-1:0]   MAGIC_ADDRS    = {20'hC0000, 20'h40000},
  parameter int                         RESULT_CHAN    = 1,
  parameter int                         HALT_CHAN      = 0,
  parameter logic [DATA_W-1:0]          PASS_CODE      = 32'hAAAAAAAA,
  parameter logic [DATA_W-1:0]          FAIL_CODE      = 32'hDEAD0000,
  parameter logic [DATA_W-1:0]          HALT_CODE      = 32'h00000001,
  parameter int                         TIMEOUT_CYCLES = 0,
  parameter int                         CNT_W          = 16,
  localparam int                        NB             = DATA_W / 8,
  localparam int                        CH_W           = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clk_50M,
  input  logic              reset_btn,
  input  logic              clear,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ce_n,
  input  logic              ram_we_n,
  input  logic [NB-1:0]     ram_be_n,
  input  logic [DATA_W-1:0] ram_data,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_chan,
  output logic [DATA_W-1:0] evt_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              halt,
  output logic              timeout,
  output logic [CNT_W-1:0]  wr_count,
  output logic [DATA_W-1:0] result_data
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic              wa;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [NB-1:0]     be_p0;

  logic              commit;
  logic              commit_hit;
  logic              hit;
  logic [CH_W-1:0]   hit_chan;
  logic [DATA_W-1:0] merged;

  logic [DATA_W-1:0] shadow [N_CHAN];

  logic [WD_W-1:0]   wd_q, wd_d;
  logic              set_pass, set_fail, set_halt, set_timeout;

  // Replace only the enabled bytes (active-low byte enables) of the old word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be_n);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (!be_n[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wa = !ram_ce_n && !ram_we_n;

  // A write ends when the strobe drops or the address moves under a held strobe.
  assign commit     = vld_p0 && (!wa || (ram_addr != addr_p0));
  assign commit_hit = commit && hit;

  // Stage p0: write-active flag; cleared by reset so a partial write never commits.
  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) vld_p0 <= 1'b0;
    else           vld_p0 <= wa;
  end

  // Stage p0: capture the bus while a write is active; the last sampled beat wins.
  always_ff @(posedge clk_50M) begin
    if (wa) begin
      addr_p0 <= ram_addr;
      data_p0 <= ram_data;
      be_p0   <= ram_be_n;
    end
  end

  // Address match; scanning from the top down lets the lowest duplicate index win.
  always_comb begin
    hit      = 1'b0;
    hit_chan = '0;
    merged   = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (addr_p0 == MAGIC_ADDRS[i*ADDR_W +: ADDR_W]) begin
        hit      = 1'b1;
        hit_chan = CH_W'(i);
        merged   = byte_merge(shadow[i], data_p0, be_p0);
      end
    end
  end

  // Run/done state register.
  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      state_q <= S_RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Terminal decode and watchdog; only active in RUN, a magic commit beats the timeout.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    set_pass    = 1'b0;
    set_fail    = 1'b0;
    set_halt    = 1'b0;
    set_timeout = 1'b0;
    if (state_q == S_RUN) begin
      if (commit_hit) begin
        wd_d = '0;
        if (hit_chan == CH_W'(RESULT_CHAN) && merged == PASS_CODE) set_pass = 1'b1;
        if (hit_chan == CH_W'(RESULT_CHAN) && merged == FAIL_CODE) set_fail = 1'b1;
        if (hit_chan == CH_W'(HALT_CHAN)   && merged == HALT_CODE) set_halt = 1'b1;
      end else if (TIMEOUT_CYCLES > 0) begin
        wd_d = wd_q + 1'b1;
        if (wd_d == WD_W'(TIMEOUT_CYCLES)) set_timeout = 1'b1;
      end
      if (set_pass || set_fail || set_halt || set_timeout) state_d = S_DONE;
    end
    if (clear) begin
      state_d     = S_RUN;
      wd_d        = '0;
      set_pass    = 1'b0;
      set_fail    = 1'b0;
      set_halt    = 1'b0;
      set_timeout = 1'b0;
    end
  end

  // Stage p1: event stream, counters, shadows and sticky flags.
  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_data  <= '0;
      wr_count  <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      halt      <= 1'b0;
      timeout   <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) shadow[i] <= '0;
    end else if (clear) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_data  <= '0;
      wr_count  <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      halt      <= 1'b0;
      timeout   <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) shadow[i] <= '0;
    end else begin
      evt_valid <= commit_hit;
      if (commit_hit) begin
        evt_chan <= hit_chan;
        evt_data <= merged;
        wr_count <= sat_inc(wr_count);
      end
      for (int i = 0; i < N_CHAN; i++) begin
        if (commit_hit && hit_chan == CH_W'(i)) shadow[i] <= merged;
      end
      pass    <= pass    | set_pass;
      fail    <= fail    | set_fail;
      halt    <= halt    | set_halt;
      timeout <= timeout | set_timeout;
    end
  end

  assign done        = (state_q == S_DONE);
  assign result_data = shadow[RESULT_CHAN];

endmodule

// File: tb/tb_sram_magic_monitor.sv
// Bench for sram_magic_monitor: directed bus transactions, a transaction-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_sram_magic_monitor;

  localparam int TMO = 100;
  localparam logic [31:0] PASS_C = 32'hAAAAAAAA;
  localparam logic [31:0] FAIL_C = 32'hDEAD0000;
  localparam logic [31:0] HALT_C = 32'h00000001;

  logic        clk_50M = 1'b0;
  logic        reset_btn;
  logic        clear;
  logic [19:0] ram_addr;
  logic        ram_ce_n;
  logic        ram_we_n;
  logic [3:0]  ram_be_n;
  logic [31:0] ram_data;
  logic        evt_valid;
  logic [0:0]  evt_chan;
  logic [31:0] evt_data;
  logic        done, pass, fail, halt, timeout;
  logic [15:0] wr_count;
  logic [31:0] result_data;

  sram_magic_monitor #(
    .ADDR_W(20), .DATA_W(32), .N_CHAN(2),
    .MAGIC_ADDRS({20'hC0000, 20'h40000}),
    .RESULT_CHAN(1), .HALT_CHAN(0),
    .PASS_CODE(PASS_C), .FAIL_CODE(FAIL_C), .HALT_CODE(HALT_C),
    .TIMEOUT_CYCLES(TMO), .CNT_W(16)
  ) dut (
    .clk_50M(clk_50M), .reset_btn(reset_btn), .clear(clear),
    .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
    .ram_be_n(ram_be_n), .ram_data(ram_data),
    .evt_valid(evt_valid), .evt_chan(evt_chan), .evt_data(evt_data),
    .done(done), .pass(pass), .fail(fail), .halt(halt), .timeout(timeout),
    .wr_count(wr_count), .result_data(result_data)
  );

  always #10 clk_50M = ~clk_50M;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [19:0] magic_tab [2] = '{20'h40000, 20'hC0000};
  logic [31:0] m_shadow [2];
  bit          m_evt, m_pass, m_fail, m_halt, m_tmo, m_done;
  int          m_chan, m_cnt, m_wd;
  logic [31:0] m_evt_data;

  bit          p_commit = 1'b0;
  bit          p_clear  = 1'b0;
  logic [19:0] p_addr;
  logic [3:0]  p_be;
  logic [31:0] p_data;

  task automatic model_reset();
    m_shadow[0] = '0; m_shadow[1] = '0;
    m_evt = 0; m_pass = 0; m_fail = 0; m_halt = 0; m_tmo = 0; m_done = 0;
    m_chan = 0; m_cnt = 0; m_wd = 0; m_evt_data = '0;
  endtask

  task automatic model_commit(output bit magic);
    int          ch;
    logic [31:0] mask;
    logic [31:0] nv;
    ch = -1;
    for (int i = 0; i < 2; i++) if (ch < 0 && magic_tab[i] == p_addr) ch = i;
    magic = (ch >= 0);
    if (magic) begin
      for (int b = 0; b < 4; b++) mask[b*8 +: 8] = p_be[b] ? 8'h00 : 8'hFF;
      nv = (m_shadow[ch] & ~mask) | (p_data & mask);
      m_shadow[ch] = nv;
      m_evt = 1; m_chan = ch; m_evt_data = nv;
      if (m_cnt < 65535) m_cnt++;
      if (!m_done) begin
        if (ch == 1 && nv == PASS_C) m_pass = 1;
        if (ch == 1 && nv == FAIL_C) m_fail = 1;
        if (ch == 0 && nv == HALT_C) m_halt = 1;
        if (m_pass || m_fail || m_halt) m_done = 1;
      end
    end
  endtask

  // Model advance: apply what the stimulus announced for this edge.
  always @(posedge clk_50M) begin
    bit magic;
    #1;
    m_evt = 0;
    magic = 0;
    if (!reset_btn) begin
      if (p_clear) model_reset();
      else begin
        if (p_commit) model_commit(magic);
        if (magic) m_wd = 0;
        else if (!m_done) begin
          m_wd++;
          if (m_wd == TMO) begin m_tmo = 1; m_done = 1; end
        end
      end
    end
    p_commit = 0;
    p_clear  = 0;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk_50M) begin
    chk("evt_valid",   evt_valid,   m_evt);
    chk("evt_chan",    evt_chan,    m_chan);
    chk("evt_data",    evt_data,    m_evt_data);
    chk("done",        done,        m_done);
    chk("pass",        pass,        m_pass);
    chk("fail",        fail,        m_fail);
    chk("halt",        halt,        m_halt);
    chk("timeout",     timeout,     m_tmo);
    chk("wr_count",    wr_count,    m_cnt);
    chk("result_data", result_data, m_shadow[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_50M); #2;
  endtask

  task automatic after_edge();
    @(posedge clk_50M); #3;
  endtask

  task automatic bus_idle();
    ram_ce_n = 1'b1; ram_we_n = 1'b1; ram_be_n = 4'hF; ram_data = 32'hFFFF_FFFF;
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [3:0] be,
                           input logic [31:0] d, input int n, input bit last);
    ram_addr = a; ram_be_n = be; ram_data = d; ram_ce_n = 1'b0; ram_we_n = 1'b0;
    repeat (n) @(posedge clk_50M);
    #2;
    p_commit = 1; p_addr = a; p_be = be; p_data = d;
    if (last) bus_idle();
  endtask

  task automatic clear_pulse();
    clear = 1'b1; p_clear = 1;
    @(posedge clk_50M); #2;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_btn = 1'b1; clear = 1'b0; ram_addr = '0; bus_idle();
    model_reset();
    repeat (3) @(posedge clk_50M);
    #2;
    chk("rst_done", done, 0);
    chk("rst_evt", evt_valid, 0);
    chk("rst_cnt", wr_count, 0);
    reset_btn = 1'b0;
    step();

    // 1: full-word pass; first beat differs, last beat must win
    ram_addr = 20'hC0000; ram_be_n = 4'h0; ram_data = 32'h11111111;
    ram_ce_n = 1'b0; ram_we_n = 1'b0;
    step();
    bus_write(20'hC0000, 4'h0, PASS_C, 1, 1);
    after_edge();
    chk("t1_evt", evt_valid, 1);
    chk("t1_chan", evt_chan, 1);
    chk("t1_data", evt_data, 32'hAAAAAAAA);
    chk("t1_pass", pass, 1);
    chk("t1_done", done, 1);
    chk("t1_cnt", wr_count, 1);
    after_edge();
    chk("t1_evt_once", evt_valid, 0);

    // 2: byte-lane merge builds FAIL_CODE on the second write
    clear_pulse();
    bus_write(20'hC0000, 4'b1100, 32'h0000_0000, 1, 1);
    after_edge();
    chk("t2_evt1", evt_valid, 1);
    chk("t2_fail1", fail, 0);
    bus_write(20'hC0000, 4'b0011, 32'hDEAD_FFFF, 1, 1);
    after_edge();
    chk("t2_data2", evt_data, 32'hDEAD0000);
    chk("t2_fail2", fail, 1);
    chk("t2_cnt", wr_count, 2);

    // 3: back-to-back writes under a held strobe
    clear_pulse();
    bus_write(20'hC0000, 4'h0, 32'h12345678, 2, 0);
    bus_write(20'h40000, 4'h0, 32'h00000001, 2, 1);
    after_edge();
    chk("t3_halt", halt, 1);
    chk("t3_chan", evt_chan, 0);
    chk("t3_result", result_data, 32'h12345678);
    chk("t3_cnt", wr_count, 2);

    // 5: first terminal condition wins; clear returns everything to zero
    clear_pulse();
    bus_write(20'hC0000, 4'h0, PASS_C, 1, 1);
    after_edge();
    chk("t5_pass", pass, 1);
    bus_write(20'hC0000, 4'h0, FAIL_C, 1, 1);
    after_edge();
    chk("t5_evt", evt_valid, 1);
    chk("t5_fail", fail, 0);
    chk("t5_result", result_data, 32'hDEAD0000);
    clear_pulse();
    #1;
    chk("t5_clr_pass", pass, 0);
    chk("t5_clr_done", done, 0);
    chk("t5_clr_cnt", wr_count, 0);

    // 4a: watchdog fires exactly at cycle 100 after clear
    clear_pulse();
    repeat (98) @(posedge clk_50M);
    #3;
    after_edge();
    chk("t4_tmo99", timeout, 0);
    after_edge();
    chk("t4_tmo100", timeout, 1);
    chk("t4_done", done, 1);

    // 4b: a commit on the limit cycle wins and restarts the count
    clear_pulse();
    repeat (97) @(posedge clk_50M);
    #2;
    bus_write(20'h40000, 4'h0, 32'h00000055, 2, 1);
    after_edge();
    chk("t4b_evt", evt_valid, 1);
    chk("t4b_tmo", timeout, 0);
    repeat (98) @(posedge clk_50M);
    #3;
    after_edge();
    chk("t4b_tmo199", timeout, 0);
    after_edge();
    chk("t4b_tmo200", timeout, 1);

    // 6: async reset mid-write loses the write; non-magic write ignored
    clear_pulse();
    bus_write(20'hC0000, 4'h0, PASS_C, 1, 1);
    after_edge();
    chk("t6_pass", pass, 1);
    ram_addr = 20'hC0000; ram_be_n = 4'h0; ram_data = FAIL_C;
    ram_ce_n = 1'b0; ram_we_n = 1'b0;
    step();
    #1;
    reset_btn = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_pass", pass, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_result", result_data, 0);
    bus_idle();
    step();
    step();
    reset_btn = 1'b0;
    after_edge();
    chk("t6_no_evt", evt_valid, 0);
    after_edge();
    chk("t6_cnt", wr_count, 0);
    bus_write(20'h00010, 4'h0, PASS_C, 1, 1);
    after_edge();
    chk("t6_nm_evt", evt_valid, 0);
    chk("t6_nm_pass", pass, 0);
    chk("t6_nm_cnt", wr_count, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
